// File: rtl/adc_power_seq.sv
// adc_power_seq: ADC supply/reset power-up sequencer with a ms timebase.
// IDLE -> PWR -> RST -> SETTLE -> READY; shutdown or rst_l returns to IDLE.
module adc_power_seq #(
    parameter int FREQ_MHZ    = 12,
    parameter int T_PWR_MS    = 5,
    parameter int T_RST_MS    = 1,
    parameter int T_SETTLE_MS = 2
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start,
    input  logic       shutdown,
    output logic       pwr_en,
    output logic       adc_rst_l,
    output logic       busy,
    output logic       ready,
    output logic [2:0] state
);
    localparam int CYC_N = FREQ_MHZ * 1000;
    localparam int CYC_W = $clog2(CYC_N);
    localparam int T_MAX = (T_PWR_MS > T_RST_MS)
                         ? ((T_PWR_MS > T_SETTLE_MS) ? T_PWR_MS : T_SETTLE_MS)
                         : ((T_RST_MS > T_SETTLE_MS) ? T_RST_MS : T_SETTLE_MS);
    localparam int MS_W = $clog2(T_MAX + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PWR    = 3'd1,
        S_RST    = 3'd2,
        S_SETTLE = 3'd3,
        S_READY  = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [CYC_W-1:0] r_cyc;
    logic [MS_W-1:0]  r_ms, w_last;
    logic             w_ms_tick, w_expire, w_clear;
    logic             r_pwr_en, r_adc_rst_l, r_busy, r_ready;

    assign w_ms_tick = r_cyc == CYC_LAST;

    always_comb begin
        w_last = '0;
        case (r_state)
            S_PWR:    w_last = MS_W'(T_PWR_MS - 1);
            S_RST:    w_last = MS_W'(T_RST_MS - 1);
            S_SETTLE: w_last = MS_W'(T_SETTLE_MS - 1);
            default:  w_last = '0;
        endcase
        // Expiry fires on the tick that would bring the ms count up to T.
        w_expire = w_ms_tick && (r_ms == w_last);
        w_next = r_state;
        if (r_state == S_IDLE)
            w_next = (start && !shutdown) ? S_PWR : S_IDLE;
        else if (shutdown)
            w_next = S_IDLE;
        else if (w_expire)
            case (r_state)
                S_PWR:    w_next = S_RST;
                S_RST:    w_next = S_SETTLE;
                S_SETTLE: w_next = S_READY;
                default:  w_next = r_state;
            endcase
        w_clear = (w_next != r_state) || (r_state == S_IDLE) || (r_state == S_READY);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_ms        <= '0;
            r_pwr_en    <= 1'b0;
            r_adc_rst_l <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cyc       <= (w_clear || w_ms_tick) ? '0 : r_cyc + CYC_W'(1);
            r_ms        <= w_clear ? '0 : r_ms + MS_W'(w_ms_tick);
            r_pwr_en    <= w_next != S_IDLE;
            r_adc_rst_l <= (w_next == S_SETTLE) || (w_next == S_READY);
            r_busy      <= (w_next == S_PWR) || (w_next == S_RST) || (w_next == S_SETTLE);
            r_ready     <= w_next == S_READY;
        end
    end

    assign pwr_en    = r_pwr_en;
    assign adc_rst_l = r_adc_rst_l;
    assign busy      = r_busy;
    assign ready     = r_ready;
    assign state     = r_state;
endmodule

// File: doc/adc_power_seq.md
ADC_POWER_SEQ -- requirements
Module: adc_power_seq

Interface
REQ-001 Parameter FREQ_MHZ, default 12: clk frequency in MHz; valid range 1..200.
REQ-002 Parameter T_PWR_MS, default 5: rail-stabilise wait after pwr_en rises, in ms; valid range 1..1000.
REQ-003 Parameter T_RST_MS, default 1: adc_rst_l low pulse width, in ms; valid range 1..1000.
REQ-004 Parameter T_SETTLE_MS, default 2: ADC settle wait after reset release, in ms; valid range 1..1000.
REQ-005 clk  input  1  block clock.
REQ-006 rst_l  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  level; a 1 in IDLE begins power-up.
REQ-008 shutdown  input  1  level; a 1 in any non-IDLE state forces immediate power-down.
REQ-009 pwr_en  output  1  ADC supply enable.
REQ-010 adc_rst_l  output  1  ADC reset, active-low.
REQ-011 busy  output  1  1 while the sequence is in progress (PWR, RST, SETTLE).
REQ-012 ready  output  1  1 only in READY.
REQ-013 state  output  3  encoding: IDLE=0, PWR=1, RST=2, SETTLE=3, READY=4.

Function
REQ-014 The block SHALL implement the FSM IDLE -> PWR -> RST -> SETTLE -> READY, with all outputs registered.
REQ-015 The ms timebase SHALL be a cycle counter of width clog2(FREQ_MHZ*1000) that wraps at FREQ_MHZ*1000-1 and issues a 1-cycle ms_tick on wrap.
REQ-016 A separate ms counter SHALL count ms_ticks; its width SHALL cover the largest of the three T_* parameters.
REQ-017 Both counters SHALL clear on every state transition, so that each timed state lasts exactly T*FREQ_MHZ*1000 cycles.
REQ-018 In IDLE, counters SHALL be held at 0; start=1 at a clock edge SHALL move the FSM to PWR on that edge.
REQ-019 PWR: pwr_en=1, adc_rst_l=0; the FSM SHALL move to RST when the ms count reaches T_PWR_MS.
REQ-020 RST: pwr_en=1, adc_rst_l=0; the FSM SHALL move to SETTLE after T_RST_MS ms.
REQ-021 SETTLE: pwr_en=1, adc_rst_l=1; the FSM SHALL move to READY after T_SETTLE_MS ms.
REQ-022 READY: pwr_en=1, adc_rst_l=1, ready=1; the FSM SHALL stay in READY until shutdown; start is ignored.
REQ-023 shutdown=1 in PWR/RST/SETTLE/READY SHALL, on the next edge, set state=IDLE, pwr_en=0, adc_rst_l=0, busy=0, ready=0, and clear both counters.
REQ-024 shutdown SHALL have priority over start and over timer expiry when they occur in the same cycle.
REQ-025 In IDLE with start=1 and shutdown=1, the FSM SHALL remain in IDLE.
REQ-026 start held high continuously SHALL cause a new sequence to begin on the edge after each return to IDLE.
REQ-027 The registered outputs SHALL change on the same edge as the state change, with no extra latency.
REQ-028 busy SHALL equal 1 exactly when state is 1, 2 or 3.

Reset
REQ-029 rst_l=0 SHALL asynchronously force state=IDLE, pwr_en=0, adc_rst_l=0, busy=0, ready=0, and both counters to 0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence identically to REQ-029.
REQ-031 After rst_l releases, the FSM SHALL wait in IDLE for start and SHALL NOT resume the aborted sequence.

Verification (FREQ_MHZ=1, T_PWR_MS=5, T_RST_MS=1, T_SETTLE_MS=2)
REQ-032 Full sequence: 1-cycle start pulse at edge E -> pwr_en=1 at E; RST at E+5000; adc_rst_l=1 (SETTLE) at E+6000; ready=1 at E+8000; ready=1 holds for 10000 further cycles.
REQ-033 Abort in RST: shutdown at E+5500 -> next edge state=0, pwr_en=0; start at E+6000 -> PWR phase lasts a full 5000 cycles again.
REQ-034 Collision: shutdown=1 on the cycle the PWR timer expires -> state=IDLE, never RST.
REQ-035 Async reset: rst_l low at E+7000, mid-cycle -> outputs reach reset values before the next edge; after release, state remains 0 with start=0.
REQ-036 Collision in IDLE: start=1 and shutdown=1 together -> state stays 0 and pwr_en stays 0.
